multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of perf counters.
REQ-002 SHALL have parameter WAIT_MAX, default 255, max ready-wait cycles per memory access; 0 = no timeout.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports opcode in 7, funct3 in 3 (from IR); brEq in 1, brLt in 1 (branch comparator).
REQ-006 SHALL have ports imem_req out 1, imem_ready in 1, dmem_ready in 1.
REQ-007 SHALL have ports pc_write, ir_write, regWrite, memRead, memWrite, ALUSrc1, ALUSrc2, PCSel, brUn out 1 each.
REQ-008 SHALL have ports memtoReg out 2 (0 ALU, 1 mem, 2 PC+4), ALUOp out 3, halted out 1, timeout out 1.
REQ-009 SHALL have ports cycle_cnt out CNT_W, retire_cnt out CNT_W (see Configuration).

Function
REQ-010 SHALL sequence states FETCH, DECODE, EXEC, MEM, WB, HALT; outputs Moore-decoded from state plus latched opcode/funct3.
REQ-011 FETCH: imem_req=1; on imem_ready, ir_write=1 for that cycle -> DECODE; ready on first cycle accepted (1-cycle fetch).
REQ-012 DECODE: one cycle; opcode latched; opcode not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111} -> HALT.
REQ-013 EXEC ALUOp: 001 R-type, 010 I-ALU, 000 add (load/store/AUIPC/JAL/JALR), 011 branch, 100 pass-B (LUI); ALUSrc1=1 for AUIPC/JAL/branch; ALUSrc2=1 all except R-type.
REQ-014 EXEC branch: taken per funct3 000 brEq, 001 !brEq, 100/110 brLt, 101/111 !brLt; brUn=1 for 110/111; 010/011 -> HALT; pc_write=1, PCSel=taken -> FETCH.
REQ-015 EXEC load/store -> MEM; all other legal opcodes -> WB.
REQ-016 MEM: memRead (load) or memWrite (store) held until dmem_ready; store on ready pulses pc_write (PCSel=0) -> FETCH; load on ready -> WB.
REQ-017 WB: regWrite=1, pc_write=1; memtoReg 1 load, 2 JAL/JALR, else 0; PCSel=1 for JAL/JALR else 0 -> FETCH.
REQ-018 Zero-wait CPI: R/I/LUI/AUIPC/JAL/JALR 4, load 5, store 4, branch 3.
REQ-019 Wait counter counts cycles in FETCH/MEM without ready; at WAIT_MAX (nonzero) -> HALT, timeout=1; counter clears on state entry.
REQ-020 HALT: all strobes 0, halted=1, stays until reset.
REQ-021 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-022 pc_write, ir_write, regWrite each SHALL be at most one-cycle pulse per instruction.

Reset
REQ-023 rst low SHALL dominate all inputs; next state FETCH; every output 0, counters 0, timeout/halted 0.
REQ-024 rst low mid-MEM SHALL drop memRead/memWrite the same cycle outputs are sampled after the edge; no pc_write/regWrite.
REQ-025 First cycle after rst high: imem_req=1.

Configuration
REQ-026 Macro MULTICYCLE_CTRL_PERF_EN defined: cycle_cnt increments every non-reset, non-HALT cycle; retire_cnt increments on each final pc_write; both wrap modulo 2^CNT_W.
REQ-027 Macro undefined: counters not built, cycle_cnt and retire_cnt tied 0.

Structure
REQ-028 Package multicycle_pkg SHALL hold state enum, opcode constants, ALUOp and memtoReg encodings.
REQ-029 Sub-module mc_branch_eval SHALL implement funct3/brEq/brLt -> taken, brUn, illegal.

Verification
REQ-030 Reset held 3 cycles, release, imem_ready=1 permanently, opcode 0110011 -> ir_write cycle 1, regWrite+pc_write cycle 4, retire_cnt=1.
REQ-031 Load 0000011, dmem_ready delayed 3 cycles -> memRead high 4 cycles, memtoReg=1 with regWrite, 8 cycles total.
REQ-032 Branch funct3=001, brEq=0 -> pc_write, PCSel=1 at cycle 3; brEq=1 -> PCSel=0.
REQ-033 Opcode 1111111 -> HALT after DECODE, halted=1, no further imem_req; rst low then high restarts fetch.
REQ-034 WAIT_MAX=4, imem_ready held 0 -> timeout=1, halted=1 after 4 FETCH cycles.
REQ-035 PERF_EN, CNT_W=4, 20 R-type instr -> retire_cnt wraps to 4; macro undefined -> both counters 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: states, opcode constants and datapath select encodings
package multicycle_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_R     = 3'b001;
  localparam logic [2:0] ALU_I     = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction
endpackage

// File: rtl/mc_branch_eval.sv
// mc_branch_eval: branch outcome, unsigned-compare select and illegal funct3 detect
module mc_branch_eval (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un,
  output logic       illegal
);
  assign illegal = funct3[2:1] == 2'b01;
  assign br_un = funct3[2:1] == 2'b11;
  assign taken = funct3[2] ? (br_lt ^ funct3[0]) : (br_eq ^ funct3[0]);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM with ready-wait timeout; perf counters under MULTICYCLE_CTRL_PERF_EN
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             brEq,
  input  logic             brLt,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic             PCSel,
  output logic             brUn,
  output logic [1:0]       memtoReg,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int WW = WAIT_MAX > 1 ? $clog2(WAIT_MAX + 1) : 1;
  state_t state, nxt;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [WW-1:0] wait_cnt;
  logic to_q, to_set, wait_exp, br_taken, br_un, br_ill;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  assign is_r = op_q == OP_R;
  assign is_i = op_q == OP_I;
  assign is_ld = op_q == OP_LOAD;
  assign is_st = op_q == OP_STORE;
  assign is_br = op_q == OP_BR;
  assign is_jal = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  assign is_lui = op_q == OP_LUI;
  assign is_auipc = op_q == OP_AUIPC;
  assign wait_exp = (WAIT_MAX != 0) && (wait_cnt == WW'(WAIT_MAX - 1));
  mc_branch_eval u_br (
    .funct3 (f3_q),
    .br_eq  (brEq),
    .br_lt  (brLt),
    .taken  (br_taken),
    .br_un  (br_un),
    .illegal(br_ill)
  );
  // state, instruction fields captured in DECODE, per-state wait counter, sticky timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      op_q <= '0;
      f3_q <= '0;
      wait_cnt <= '0;
      to_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
      wait_cnt <= (nxt != state) ? '0 : wait_cnt + 1'b1;
      to_q <= to_q | to_set;
    end
  end
  // next state and Moore strobes; a low rst forces every strobe to 0 immediately
  always_comb begin
    nxt = state;
    to_set = 1'b0;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    regWrite = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    ALUSrc1 = 1'b0;
    ALUSrc2 = 1'b0;
    PCSel = 1'b0;
    brUn = 1'b0;
    memtoReg = WB_ALU;
    ALUOp = ALU_ADD;
    halted = 1'b0;
    timeout = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          to_set = !imem_ready && wait_exp;
          nxt = imem_ready ? S_DECODE : to_set ? S_HALT : S_FETCH;
        end
        S_DECODE: nxt = op_legal(opcode) ? S_EXEC : S_HALT;
        S_EXEC: begin
          ALUOp = is_r ? ALU_R : is_i ? ALU_I : is_br ? ALU_BR : is_lui ? ALU_PASSB : ALU_ADD;
          ALUSrc1 = is_auipc | is_jal | is_br;
          ALUSrc2 = !is_r;
          brUn = is_br & br_un;
          pc_write = is_br & !br_ill;
          PCSel = is_br & br_taken & !br_ill;
          nxt = is_br ? (br_ill ? S_HALT : S_FETCH) : (is_ld | is_st) ? S_MEM : S_WB;
        end
        S_MEM: begin
          memRead = is_ld;
          memWrite = is_st;
          pc_write = is_st & dmem_ready;
          to_set = !dmem_ready && wait_exp;
          nxt = dmem_ready ? (is_st ? S_FETCH : S_WB) : to_set ? S_HALT : S_MEM;
        end
        S_WB: begin
          regWrite = 1'b1;
          pc_write = 1'b1;
          memtoReg = is_ld ? WB_MEM : (is_jal | is_jalr) ? WB_PC4 : WB_ALU;
          PCSel = is_jal | is_jalr;
          nxt = S_FETCH;
        end
        default: begin
          halted = 1'b1;
          timeout = to_q;
        end
      endcase
    end
  end
`ifdef MULTICYCLE_CTRL_PERF_EN
  // active-cycle and retired-instruction counters, wrapping at 2^CNT_W
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_write) retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-instruction timelines checked every cycle against an instruction-level model
module tb_multicycle_ctrl;
  localparam logic [6:0] R_T = 7'b0110011, I_T = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, BAD = 7'b1111111;
`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic imem_req, ir_write, pc_write, regWrite, memRead, memWrite, ALUSrc1, ALUSrc2, PCSel, brUn;
    logic [1:0] memtoReg;
    logic [2:0] ALUOp;
    logic halted, timeout;
  } outs_t;
  logic clk, rst, brEq, brLt, imem_req, imem_ready, dmem_ready;
  logic pc_write, ir_write, regWrite, memRead, memWrite, ALUSrc1, ALUSrc2, PCSel, brUn, halted, timeout;
  logic [6:0] opcode;
  logic [2:0] funct3, ALUOp;
  logic [1:0] memtoReg;
  logic [3:0] cycle_cnt, retire_cnt;
  outs_t act, ce;
  outs_t exp_q[$];
  string tag_q[$];
  logic rst_q[$];
  string ct;
  logic cr, cur_rst, cur_eq, cur_lt;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  int n_chk, n_fail, cyc_m, ret_m, lat, mr_run;

  multicycle_ctrl #(.CNT_W(4), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .brEq(brEq), .brLt(brLt),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .regWrite(regWrite), .memRead(memRead),
    .memWrite(memWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .PCSel(PCSel), .brUn(brUn),
    .memtoReg(memtoReg), .ALUOp(ALUOp), .halted(halted), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );
  assign act = {imem_req, ir_write, pc_write, regWrite, memRead, memWrite, ALUSrc1, ALUSrc2,
                PCSel, brUn, memtoReg, ALUOp, halted, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_legal(input logic [6:0] op);
    return op inside {R_T, I_T, LD, ST, BR, JAL, JALR, LUI, AUIPC};
  endfunction
  function automatic logic [2:0] m_aluop(input logic [6:0] op);
    case (op)
      R_T: return 3'd1;
      I_T: return 3'd2;
      BR: return 3'd3;
      LUI: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic m_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      default: return !lt;
    endcase
  endfunction
  function automatic logic [3:0] cnt_exp(input int v);
    return PERF ? 4'(v % 16) : 4'd0;
  endfunction

  // per-cycle compare against the expected timeline, plus the counter model and latency monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      ct = tag_q.pop_front();
      cr = rst_q.pop_front();
      n_chk++;
      if (act !== ce) begin
        n_fail++;
        $display("FAIL %s: outputs got %h expected %h", ct, act, ce);
      end
      n_chk++;
      if (cycle_cnt !== cnt_exp(cyc_m) || retire_cnt !== cnt_exp(ret_m)) begin
        n_fail++;
        $display("FAIL %s counters: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d", ct,
                 cycle_cnt, retire_cnt, cnt_exp(cyc_m), cnt_exp(ret_m));
      end
      if (cr) begin
        cyc_m = 0;
        ret_m = 0;
      end else begin
        if (!ce.halted) cyc_m++;
        if (ce.pc_write) ret_m++;
      end
    end
    if (ir_write) begin
      lat = 1;
      mr_run = 0;
    end else begin
      lat++;
      if (memRead) mr_run++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input outs_t e, input logic ir, input logic dr, input string t);
    @(posedge clk);
    #1;
    rst = cur_rst;
    opcode = cur_op;
    funct3 = cur_f3;
    brEq = cur_eq;
    brLt = cur_lt;
    imem_ready = ir;
    dmem_ready = dr;
    exp_q.push_back(e);
    tag_q.push_back(t);
    rst_q.push_back(!cur_rst);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rst_seq(input int n);
    cur_rst = 1'b0;
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b1, "reset");
    cur_rst = 1'b1;
  endtask

  task automatic halt_seq(input int n, input logic to);
    outs_t e;
    e = '0;
    e.halted = 1'b1;
    e.timeout = to;
    for (int i = 0; i < n; i++) step(e, 1'b1, 1'b1, "halt");
  endtask

  // expected timeline of one instruction: fetch waits, fetch, decode, exec, mem waits, mem, wb
  task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic eq,
                       input logic lt, input int idly, input int ddly, input bit cut);
    outs_t e;
    cur_op = op;
    cur_f3 = f3;
    cur_eq = eq;
    cur_lt = lt;
    for (int i = 0; i < idly; i++) begin
      e = '0;
      e.imem_req = 1'b1;
      step(e, 1'b0, 1'b1, {nm, ".fetch_wait"});
    end
    e = '0;
    e.imem_req = 1'b1;
    e.ir_write = 1'b1;
    step(e, 1'b1, 1'b1, {nm, ".fetch"});
    step('0, 1'b1, 1'b1, {nm, ".decode"});
    if (!m_legal(op)) return;
    e = '0;
    e.ALUOp = m_aluop(op);
    e.ALUSrc1 = op inside {AUIPC, JAL, BR};
    e.ALUSrc2 = op != R_T;
    if (op == BR) begin
      e.brUn = f3[2:1] == 2'b11;
      if (f3[2:1] != 2'b01) begin
        e.pc_write = 1'b1;
        e.PCSel = m_taken(f3, eq, lt);
      end
      step(e, 1'b1, 1'b1, {nm, ".exec"});
      return;
    end
    step(e, 1'b1, 1'b1, {nm, ".exec"});
    if (op == LD || op == ST) begin
      e = '0;
      e.memRead = op == LD;
      e.memWrite = op == ST;
      for (int i = 0; i < ddly; i++) step(e, 1'b1, 1'b0, {nm, ".mem_wait"});
      if (cut) begin
        cur_rst = 1'b0;
        step('0, 1'b1, 1'b1, {nm, ".mem_reset"});
        return;
      end
      e.pc_write = op == ST;
      step(e, 1'b1, 1'b1, {nm, ".mem"});
      if (op == ST) return;
    end
    e = '0;
    e.regWrite = 1'b1;
    e.pc_write = 1'b1;
    e.memtoReg = op == LD ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
    e.PCSel = op == JAL || op == JALR;
    step(e, 1'b1, 1'b1, {nm, ".wb"});
  endtask

  initial begin
    outs_t e;
    n_chk = 0;
    n_fail = 0;
    cyc_m = 0;
    ret_m = 0;
    lat = 0;
    mr_run = 0;
    rst = 1'b0;
    cur_rst = 1'b0;
    opcode = '0;
    funct3 = '0;
    brEq = 1'b0;
    brLt = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    cur_op = '0;
    cur_f3 = '0;
    cur_eq = 1'b0;
    cur_lt = 1'b0;
    rst_seq(3);
    instr("rtype", R_T, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("rtype_latency", lat, 4);
    chk("rtype_regwrite", regWrite, 1);
    instr("load_d3", LD, 3'd2, 1'b0, 1'b0, 0, 3, 1'b0);
    settle();
    chk("load_latency", lat, 8);
    chk("load_memread_cycles", mr_run, 4);
    chk("load_memtoreg", memtoReg, 1);
    chk("retire_after_first", retire_cnt, PERF ? 1 : 0);
    instr("itype", I_T, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr("lui", LUI, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr("auipc", AUIPC, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr("jal", JAL, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("jal_latency", lat, 4);
    chk("jal_memtoreg", memtoReg, 2);
    instr("jalr", JALR, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr("store_d0", ST, 3'd2, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("store_latency", lat, 4);
    instr("store_d3", ST, 3'd2, 1'b0, 1'b0, 0, 3, 1'b0);
    settle();
    chk("store_wait3_latency", lat, 7);
    instr("load_d0", LD, 3'd2, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("load_latency_nowait", lat, 5);
    instr("rtype_iwait", R_T, 3'd0, 1'b0, 1'b0, 2, 0, 1'b0);
    instr("bne_taken", BR, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("bne_latency", lat, 3);
    chk("bne_taken_pcsel", PCSel, 1);
    instr("bne_not", BR, 3'd1, 1'b1, 1'b0, 0, 0, 1'b0);
    settle();
    chk("bne_not_pcsel", PCSel, 0);
    chk("bne_not_pcwrite", pc_write, 1);
    instr("beq", BR, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    instr("blt", BR, 3'd4, 1'b0, 1'b1, 0, 0, 1'b0);
    instr("bge", BR, 3'd5, 1'b0, 1'b1, 0, 0, 1'b0);
    instr("bltu", BR, 3'd6, 1'b0, 1'b1, 0, 0, 1'b0);
    instr("bgeu", BR, 3'd7, 1'b0, 1'b0, 0, 0, 1'b0);
    instr("br_f3_010", BR, 3'd2, 1'b1, 1'b1, 0, 0, 1'b0);
    halt_seq(3, 1'b0);
    rst_seq(1);
    instr("bad_op", BAD, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    halt_seq(3, 1'b0);
    settle();
    chk("bad_op_halted", halted, 1);
    chk("bad_op_no_fetch", imem_req, 0);
    rst_seq(2);
    instr("restart", R_T, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    settle();
    chk("restart_latency", lat, 4);
    instr("load_cut", LD, 3'd2, 1'b0, 1'b0, 0, 2, 1'b1);
    settle();
    chk("cut_memread", memRead, 0);
    chk("cut_regwrite", regWrite, 0);
    rst_seq(1);
    instr("after_cut", R_T, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    e = '0;
    e.imem_req = 1'b1;
    for (int i = 0; i < 4; i++) step(e, 1'b0, 1'b1, "imem_timeout.wait");
    halt_seq(3, 1'b1);
    settle();
    chk("timeout_flag", timeout, 1);
    chk("timeout_halted", halted, 1);
    rst_seq(2);
    for (int i = 0; i < 20; i++) instr("perf_r", R_T, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    rst_seq(1);
    settle();
    chk("retire_wrap", retire_cnt, PERF ? 4 : 0);
    chk("cycle_wrap", cycle_cnt, PERF ? 0 : 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
